sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
Frame-level sequencer for the 3x3 Sobel window and line-buffer datapath.
- Accepts a raster pixel stream with start-of-frame marking.
- Issues the datapath shift enable and the datapath output enable as two separate pins; the datapath revision paired with this block splits its single control pin into these two.
- Tags each interior result with valid, coordinates and frame/line markers.
- Signals frame completion.
- Sits between the camera/stream source and the Sobel datapath.

Parameters:
SIZE_X, 640, pixels per line (>=4)
SIZE_Y, 480, lines per frame (>=4)
PIPE_LAT, 3, clocks from a shift edge until the datapath result register holds that window's result
X_W, 10, width of column counters and out_x (2^X_W >= SIZE_X)
Y_W, 9, width of row counters and out_y (2^Y_W >= SIZE_Y)

Ports:
clock  in  1  master clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input pixel present this cycle
in_sof  in  1  qualifies the current pixel as frame pixel (0,0)
in_ready  out  1  block can take a pixel this cycle
dp_shift_en  out  1  datapath window/line-buffer shift enable (combinational accept)
dp_out_en  out  1  datapath output gate; equals out_valid
out_valid  out  1  datapath result register holds an interior Sobel pixel this cycle
out_sof  out  1  with out_valid: first interior pixel (x=1,y=1)
out_eol  out  1  with out_valid: last interior pixel of a line (x=SIZE_X-2)
out_x  out  X_W  centre column of current result
out_y  out  Y_W  centre row of current result
frame_done  out  1  one-cycle pulse after the last result of a frame
busy  out  1  state != IDLE
err  out  1  sticky protocol error (only with SOBEL_CTRL_ERR_EN, else tied 0)

Behaviour:
- Reset (async, reset_n=0) values:
  - state=IDLE; col=row=0.
  - Valid pipe cleared.
  - All outputs 0 except in_ready=1.
  - err=0.
- Reset mid-frame abandons the frame; no frame_done is issued.
- States and transitions:
  - IDLE:
    - in_ready=1.
    - A pixel with in_valid=1, in_sof=1 is accepted as (0,0), sets col=1, and moves to RUN.
    - Pixels without in_sof are consumed (in_ready=1) and discarded: dp_shift_en=0.
  - RUN:
    - in_ready=1.
    - accept = in_valid; dp_shift_en = accept.
    - On accept: col increments; at col=SIZE_X-1 it wraps to 0 and row increments.
    - Accepting (SIZE_X-1, SIZE_Y-1) moves to DRAIN.
    - in_sof in RUN is ignored (treated as an ordinary pixel) unless SOBEL_CTRL_ERR_EN is defined.
  - DRAIN:
    - in_ready=0; dp_shift_en=0.
    - A down-counter runs PIPE_LAT cycles, then:
      - state goes to IDLE;
      - frame_done=1 for exactly one cycle (the cycle after the last out_valid).
- Tagging:
  - An accept of pixel (r,c) with r>=2 and c>=2 is a full window, with centre (r-1, c-1).
  - Full windows push {1, c-1, r-1, sof=(r==2&&c==2), eol=(c==SIZE_X-1)} into a PIPE_LAT-deep shift register.
  - Non-full accepts push valid=0.
- Pipe timing:
  - The pipe advances every clock, not gated by accept, matching the free-running datapath stages.
  - out_valid, out_x, out_y, out_sof and out_eol are the pipe tail, registered.
  - out_valid therefore rises exactly PIPE_LAT clocks after the accepting edge.
- Output count per frame: (SIZE_X-2)*(SIZE_Y-2) out_valid pulses.
- Border windows (row/col 0 and last) never assert out_valid.
- Stalls: in_valid gaps in RUN only pause the counters; pipe entries already issued still emerge on schedule.
- Back-to-back frames: a new in_sof is accepted the cycle state returns to IDLE. Input is stalled for PIPE_LAT cycles per frame.

Optional Feature:
SOBEL_CTRL_ERR_EN.
- Defined:
  - in_sof with in_valid in RUN sets err (sticky until reset).
  - That pixel is accepted as (0,0) and col=1; pipe entries in flight still emerge; no frame_done for the aborted frame.
  - In IDLE, a discarded pixel without sof also sets err.
- Undefined:
  - No err logic; err tied 0.
  - Mid-frame sof is ignored as described in Behaviour.

Decomposition:
- Package sobel_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - pipe-entry struct {valid, x, y, sof, eol};
  - default SIZE_X/SIZE_Y/PIPE_LAT constants.
- Sub-module sobel_tag_pipe: parameterised PIPE_LAT-deep free-running delay line of pipe-entry structs with async reset.
- Counters and FSM stay in the top.

Test Plan:
- SIZE_X=8, SIZE_Y=6, continuous in_valid, sof on first pixel:
  - 24 out_valid pulses;
  - first has out_x=1, out_y=1, out_sof=1, arriving 3 clocks after accept of (2,2);
  - out_eol on every x=6;
  - frame_done 1 cycle after the last pulse.
- Same frame with in_valid toggling 1/0:
  - identical coordinate sequence;
  - each out_valid exactly 3 clocks after its accepting edge;
  - in_ready low only during the 3 DRAIN cycles.
- Pixels before first sof (5 without sof): dp_shift_en stays 0, busy=0; the frame then starts normally on the sof pixel.
- reset_n pulsed low mid-RUN at (3,4):
  - all outputs 0 immediately (async), in_ready=1;
  - no frame_done;
  - the next sof starts a clean frame.
- Back-to-back frames: the second sof is presented the cycle frame_done is high and accepted; 48 total out_valid pulses.
- With SOBEL_CTRL_ERR_EN, sof at (2,3): err=1 and stays 1; counters restart at (0,0); next full frame yields 24 pulses. Without the macro: err=0 and the frame continues uninterrupted.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel frame controller.
package sobel_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int DEF_SIZE_X   = 640;
   localparam int DEF_SIZE_Y   = 480;
   localparam int DEF_PIPE_LAT = 3;
   localparam int DEF_X_W      = 10;
   localparam int DEF_Y_W      = 9;

   typedef struct packed {
      logic               valid;
      logic [DEF_X_W-1:0] x;
      logic [DEF_Y_W-1:0] y;
      logic               sof;
      logic               eol;
   } pipe_entry_t;

endpackage

// File: rtl/sobel_tag_pipe.sv
// Free-running delay line for result tags; tracks the datapath stages one-for-one.
module sobel_tag_pipe
   import sobel_pkg::*;
#(
   parameter int  DEPTH   = DEF_PIPE_LAT,
   parameter type entry_t = pipe_entry_t
) (
   input  logic   clock,
   input  logic   reset_n,
   input  entry_t din,
   output entry_t dout
);

   entry_t stg [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      end else begin
         stg[0] <= din;
         for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
   end

   assign dout = stg[DEPTH-1];

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel window datapath: counts raster pixels, tags interior results.
// Optional SOBEL_CTRL_ERR_EN: sticky protocol error on stray or mid-frame sof.
module sobel_frame_ctrl
   import sobel_pkg::*;
#(
   parameter int SIZE_X   = DEF_SIZE_X,
   parameter int SIZE_Y   = DEF_SIZE_Y,
   parameter int PIPE_LAT = DEF_PIPE_LAT,
   parameter int X_W      = DEF_X_W,
   parameter int Y_W      = DEF_Y_W
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           in_valid,
   input  logic           in_sof,
   output logic           in_ready,
   output logic           dp_shift_en,
   output logic           dp_out_en,
   output logic           out_valid,
   output logic           out_sof,
   output logic           out_eol,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic           frame_done,
   output logic           busy,
   output logic           err
);

   localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   typedef struct packed {
      logic           valid;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic           sof;
      logic           eol;
   } tag_t;

   state_t           state, state_nx;
   logic [X_W-1:0]   col, col_nx;
   logic [Y_W-1:0]   row, row_nx;
   logic [CNT_W-1:0] dcnt, dcnt_nx;
   logic             accept, restart, drain_end, done_q;
   tag_t             push, tail;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_nx;
         col   <= col_nx;
         row   <= row_nx;
         dcnt  <= dcnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      col_nx   = col;
      row_nx   = row;
      dcnt_nx  = dcnt;
      accept   = 1'b0;
      restart  = 1'b0;
      in_ready = 1'b1;
      case (state)
         IDLE: begin
            accept = in_valid && in_sof;
            if (accept) begin
               col_nx   = X_W'(1);
               row_nx   = '0;
               state_nx = RUN;
            end
         end
         RUN: begin
            accept = in_valid;
            if (in_valid) begin
`ifdef SOBEL_CTRL_ERR_EN
               restart = in_sof;
`endif
               if (restart) begin
                  col_nx = X_W'(1);
                  row_nx = '0;
               end else if (col == X_W'(SIZE_X-1)) begin
                  col_nx = '0;
                  if (row == Y_W'(SIZE_Y-1)) begin
                     row_nx   = '0;
                     dcnt_nx  = CNT_W'(PIPE_LAT-1);
                     state_nx = DRAIN;
                  end else begin
                     row_nx = row + Y_W'(1);
                  end
               end else begin
                  col_nx = col + X_W'(1);
               end
            end
         end
         DRAIN: begin
            in_ready = 1'b0;
            if (dcnt == '0) state_nx = IDLE;
            else            dcnt_nx  = dcnt - CNT_W'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   // Window is full once two rows and two columns of history exist; tag its centre.
   always_comb begin
      push = '0;
      if (accept && !restart && row >= Y_W'(2) && col >= X_W'(2)) begin
         push.valid = 1'b1;
         push.x     = col - X_W'(1);
         push.y     = row - Y_W'(1);
         push.sof   = (row == Y_W'(2)) && (col == X_W'(2));
         push.eol   = (col == X_W'(SIZE_X-1));
      end
   end

   sobel_tag_pipe #(.DEPTH(PIPE_LAT), .entry_t(tag_t)) u_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .din     (push),
      .dout    (tail)
   );

   assign drain_end = (state == DRAIN) && (dcnt == '0);

   // frame_done trails the state return to IDLE by one clock so it lands after the last result.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_sof    <= 1'b0;
         out_eol    <= 1'b0;
         out_x      <= '0;
         out_y      <= '0;
         done_q     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= tail.valid;
         out_sof    <= tail.sof;
         out_eol    <= tail.eol;
         out_x      <= tail.x;
         out_y      <= tail.y;
         done_q     <= drain_end;
         frame_done <= done_q;
      end
   end

   assign dp_shift_en = accept;
   assign dp_out_en   = out_valid;
   assign busy        = (state != IDLE);

`ifdef SOBEL_CTRL_ERR_EN
   logic err_set;
   assign err_set = restart || ((state == IDLE) && in_valid && !in_sof);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on an 8x6 frame; the reference model works on linear pixel indices.
module tb_sobel_frame_ctrl;

   localparam int SX = 8, SY = 6, LAT = 3, XW = 10, YW = 9;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0, in_sof = 1'b0;
   logic          in_ready, dp_shift_en, dp_out_en, out_valid, out_sof, out_eol;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          frame_done, busy, err;

   sobel_frame_ctrl #(.SIZE_X(SX), .SIZE_Y(SY), .PIPE_LAT(LAT), .X_W(XW), .Y_W(YW)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof),
      .in_ready(in_ready), .dp_shift_en(dp_shift_en), .dp_out_en(dp_out_en),
      .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
      .out_x(out_x), .out_y(out_y), .frame_done(frame_done), .busy(busy), .err(err)
   );

   always #5 clock = ~clock;

   typedef struct { int x; int y; bit sof; bit eol; int due; } exp_t;
   exp_t oq[$];
   int   fdq[$];

   int cyc = 0, checks = 0, errors = 0, pulses = 0, frames = 0;
   bit in_frame = 0;
   int p = 0, blk_until = 0, err_from = 1 << 30;
   bit exp_ready = 1, exp_shift = 0, exp_busy = 0, mon_en = 0;

   always @(posedge clock) cyc++;

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Present one input beat and predict its effect at the coming edge.
   task automatic step(input bit v, input bit s);
      int n, r, c;
      bit acc;
      @(posedge clock); #1;
      n = cyc;
      in_valid = v;
      in_sof   = s;
      exp_ready = (n >= blk_until);
      exp_busy  = in_frame || (n < blk_until);
      acc = 0;
      if (exp_ready) begin
         if (!in_frame) begin
            if (v && s) begin acc = 1; in_frame = 1; p = 0; end
`ifdef SOBEL_CTRL_ERR_EN
            else if (v && err_from > n + 1) err_from = n + 1;
`endif
         end else if (v) begin
            acc = 1;
`ifdef SOBEL_CTRL_ERR_EN
            if (s) begin p = 0; if (err_from > n + 1) err_from = n + 1; end
`endif
         end
      end
      exp_shift = acc;
      if (acc) begin
         r = p / SX;
         c = p % SX;
         if (r >= 2 && c >= 2)
            oq.push_back('{c - 1, r - 1, (r == 2 && c == 2), (c == SX - 1), n + 1 + LAT});
         p++;
         if (p == SX * SY) begin
            in_frame  = 0;
            blk_until = n + 1 + LAT;
            fdq.push_back(n + 2 + LAT);
            frames++;
         end
      end
   endtask

   task automatic run_frame(input bit rnd);
      int f0, guard;
      bit v;
      f0 = frames;
      guard = 0;
      while (frames == f0 && guard < 2000) begin
         v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step(v, !in_frame);
         guard++;
      end
      chk("frame_timeout", (guard < 2000) ? 1 : 0, 1);
   endtask

   always @(negedge clock) begin : mon
      exp_t e;
      bit   eo, ef;
      if (mon_en) begin
         chk("in_ready", in_ready, exp_ready);
         chk("dp_shift_en", dp_shift_en, exp_shift);
         chk("busy", busy, exp_busy);
         chk("err", err, (cyc >= err_from) ? 1 : 0);
         eo = (oq.size() > 0) && (oq[0].due == cyc);
         chk("out_valid", out_valid, eo);
         chk("dp_out_en", dp_out_en, eo);
         if (eo) begin
            e = oq.pop_front();
            if (out_valid) begin
               chk("out_x", out_x, e.x);
               chk("out_y", out_y, e.y);
               chk("out_sof", out_sof, e.sof);
               chk("out_eol", out_eol, e.eol);
            end
         end
         if (out_valid) pulses++;
         ef = (fdq.size() > 0) && (fdq[0] == cyc);
         chk("frame_done", frame_done, ef);
         if (ef) void'(fdq.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err", err, 0);
      chk("rst_out_x", out_x, 0);
      #10 reset_n = 1'b1;
      mon_en = 1;

      // stray pixels before any sof are discarded
      repeat (5) step(1, 0);

      // frame 1 continuous, then back-to-back sof on the frame_done cycle
      run_frame(0);
      repeat (LAT + 1) step(0, 0);
      step(1, 1);
      chk("fd_with_b2b_sof", frame_done, 1);
      chk("frame1_pulses", pulses, (SX - 2) * (SY - 2));
      run_frame(0);
      repeat (LAT + 2) step(0, 0);
      chk("b2b_pulses", pulses, 2 * (SX - 2) * (SY - 2));

      // randomly gapped input
      base = pulses;
      run_frame(1);
      repeat (LAT + 3) step($urandom_range(0, 1) == 1, 1);
      chk("gapped_pulses", pulses - base, (SX - 2) * (SY - 2));

      // async reset with pixel (3,4) on the input
      while (!(in_frame && p == 3 * SX + 5)) step(1, !in_frame);
      #1;
      mon_en = 0;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_shift", dp_shift_en, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      chk("mid_rst_out_y", out_y, 0);
      oq.delete();
      fdq.delete();
      in_frame = 0; p = 0; blk_until = 0; err_from = 1 << 30;
      in_valid = 0; in_sof = 0;
      exp_ready = 1; exp_shift = 0; exp_busy = 0;
      #10 reset_n = 1'b1;
      mon_en = 1;
      repeat (4) step(0, 0);
      base = pulses;
      run_frame(1);
      repeat (LAT + 2) step(0, 0);
      chk("post_rst_pulses", pulses - base, (SX - 2) * (SY - 2));

      // sof arriving at (2,3) mid-frame
      base = pulses;
      while (!(in_frame && p == 2 * SX + 3)) step(1, !in_frame);
      step(1, 1);
      run_frame(0);
      repeat (LAT + 2) step(0, 0);
`ifdef SOBEL_CTRL_ERR_EN
      chk("midsof_pulses", pulses - base, (SX - 2) * (SY - 2) + 1);
      chk("err_sticky", err, 1);
`else
      chk("midsof_pulses", pulses - base, (SX - 2) * (SY - 2));
      chk("err_tied", err, 0);
`endif

      repeat (4) step(0, 0);
      chk("queues_empty", oq.size() + fdq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
